// File: rtl/bitwise_op_driver.sv
// Request/response driver for an external combinational bitwise operator unit.
// Optional BITWISE_SELFCHECK_EN adds a reference model that flags bad results.
module bitwise_op_driver #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_op_code,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic [15:0]      txn_count,
  output logic             mismatch
);

  // state  | meaning
  // IDLE   | ready for a request
  // DRIVE  | operands on alu_*, waiting for the unit to settle
  // RESP   | response presented, waiting for rsp_ready
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_x_q, alu_x_d;
  logic [WIDTH-1:0] alu_y_q, alu_y_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      txn_q, txn_d;
  logic             op_legal;
  logic             capture;
  logic             chk_fail;

  assign op_legal = (req_op <= 3'b101);
  assign capture  = (state_q == S_DRIVE) && (cnt_q <= 4'd1);

`ifdef BITWISE_SELFCHECK_EN
  logic             mismatch_q;
  logic [WIDTH-1:0] expected;

  always_comb begin
    expected = '0;
    case (alu_op_q)
      3'b000:  expected = alu_x_q & alu_y_q;
      3'b001:  expected = ~(alu_x_q & alu_y_q);
      3'b010:  expected = alu_x_q | alu_y_q;
      3'b011:  expected = ~(alu_x_q | alu_y_q);
      3'b100:  expected = alu_x_q ^ alu_y_q;
      3'b101:  expected = ~(alu_x_q ^ alu_y_q);
      default: expected = '0;
    endcase
  end

  assign chk_fail = (alu_result != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (capture && chk_fail) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign chk_fail = 1'b0;
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    txn_d        = txn_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (op_legal) begin
            alu_x_d  = req_x;
            alu_y_d  = req_y;
            alu_op_d = req_op;
            cnt_d    = SETTLE_LD;
            state_d  = S_DRIVE;
          end else begin
            // Illegal ops never reach the unit; alu_* keep the last operands.
            rsp_result_d = '0;
            rsp_op_d     = req_op;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      S_DRIVE: begin
        if (capture) begin
          cnt_d        = 4'd0;
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = chk_fail;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          txn_d   = txn_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_op_q     <= 3'b000;
      rsp_result_q <= '0;
      rsp_op_q     <= 3'b000;
      rsp_err_q    <= 1'b0;
      txn_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
      txn_q        <= txn_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign alu_x       = alu_x_q;
  assign alu_y       = alu_y_q;
  assign alu_op_code = alu_op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_err     = rsp_err_q;
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_bitwise_op_driver.sv
// Bench for bitwise_op_driver: vector table, corner sequences, random traffic.
// Honours BITWISE_SELFCHECK_EN when the design is built with it.
module tb_bitwise_op_driver;

  localparam int W  = 8;
  localparam int SC = 1;
`ifdef BITWISE_SELFCHECK_EN
  localparam bit SELF = 1'b1;
`else
  localparam bit SELF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_x = '0;
  logic [W-1:0] req_y = '0;
  logic [2:0]   req_op = 3'b000;
  logic [W-1:0] alu_x, alu_y;
  logic [2:0]   alu_op_code;
  logic [W-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic [2:0]   rsp_op;
  logic         rsp_err;
  logic [15:0]  txn_count;
  logic         mismatch;
  logic         force_zero = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] last_x = '0, last_y = '0;
  logic [2:0]   last_op = 3'b000;
  int exp_txn = 0;

  always #5 clk = ~clk;

  bitwise_op_driver #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op_code(alu_op_code),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .txn_count(txn_count), .mismatch(mismatch)
  );

  // The external operator unit; force_zero emulates a broken unit.
  always_comb begin
    alu_result = '0;
    case (alu_op_code)
      3'b000:  alu_result = alu_x & alu_y;
      3'b001:  alu_result = ~(alu_x & alu_y);
      3'b010:  alu_result = alu_x | alu_y;
      3'b011:  alu_result = ~(alu_x | alu_y);
      3'b100:  alu_result = alu_x ^ alu_y;
      3'b101:  alu_result = ~(alu_x ^ alu_y);
      default: alu_result = '0;
    endcase
    if (force_zero) alu_result = '0;
  end

  // Reference: per-bit truth table lookup, index {x_bit, y_bit}.
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [2:0] op);
    logic [3:0] tt;
    logic [W-1:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b0111;
      3'd2:    tt = 4'b1110;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0110;
      3'd5:    tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_x = '0; last_y = '0; last_op = 3'b000;
    exp_txn = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " alu_x"}, 32'(alu_x), 32'd0);
    chk({tag, " alu_y"}, 32'(alu_y), 32'd0);
    chk({tag, " alu_op"}, 32'(alu_op_code), 32'd0);
    chk({tag, " rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, " rsp_op"}, 32'(rsp_op), 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " txn_count"}, 32'(txn_count), 32'd0);
    chk({tag, " mismatch"}, 32'(mismatch), 32'd0);
  endtask

  task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                         input logic [W-1:0] exp_res, input logic exp_err,
                         input int hold, input string tag);
    int t;
    int lat;
    logic illegal;
    illegal = (op > 3'd5);
    @(negedge clk);
    req_x = x; req_y = y; req_op = op; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) begin
      timeout({tag, " accept"});
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      timeout({tag, " response"});
      return;
    end
    chk({tag, " latency"}, 32'(lat), illegal ? 32'd1 : 32'(SC + 1));
    if (!illegal) begin
      last_x = x; last_y = y; last_op = op;
    end
    chk({tag, " alu_x"}, 32'(alu_x), 32'(last_x));
    chk({tag, " alu_y"}, 32'(alu_y), 32'(last_y));
    chk({tag, " alu_op"}, 32'(alu_op_code), 32'(last_op));
    chk({tag, " rsp_result"}, 32'(rsp_result), 32'(exp_res));
    chk({tag, " rsp_op"}, 32'(rsp_op), 32'(op));
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_x = ~x; req_y = ~y; req_op = 3'b010;
      @(negedge clk);
      chk({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " hold rsp_result"}, 32'(rsp_result), 32'(exp_res));
      chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " hold alu_x"}, 32'(alu_x), 32'(last_x));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_txn = (exp_txn + 1) % 65536;
    chk({tag, " txn_count"}, 32'(txn_count), 32'(exp_txn));
    chk({tag, " post req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'b00010101, 8'b11000111, 3'b000, 8'h05, 1'b0};
    tbl[1] = '{8'b00010101, 8'b11000111, 3'b001, 8'hFA, 1'b0};
    tbl[2] = '{8'b10010101, 8'b01101111, 3'b010, 8'hFF, 1'b0};
    tbl[3] = '{8'b10010101, 8'b01101111, 3'b011, 8'h00, 1'b0};
    tbl[4] = '{8'b01011001, 8'b01101100, 3'b100, 8'h35, 1'b0};
    tbl[5] = '{8'b01011001, 8'b01101100, 3'b101, 8'hCA, 1'b0};
    tbl[6] = '{8'b01101100, 8'b01101100, 3'b101, 8'hFF, 1'b0};
    tbl[7] = '{8'hA5,       8'h3C,       3'b110, 8'h00, 1'b1};
    tbl[8] = '{8'h5A,       8'h0F,       3'b111, 8'h00, 1'b1};

    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].res, tbl[i].err, 0,
              $sformatf("vec%0d", i));
      if (i == 1) chk("vec pair txn_count", 32'(txn_count), 32'd2);
    end

    run_txn(8'h33, 8'hF0, 3'b010, 8'hF3, 1'b0, 5, "backpressure");

    // Reset while in DRIVE discards the transaction.
    @(negedge clk);
    req_x = 8'hC3; req_y = 8'h0F; req_op = 3'b100; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_x = '0; last_y = '0; last_op = 3'b000; exp_txn = 0;
    chk_reset_state("drive_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drive_rst no rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(8'hC3, 8'h0F, 3'b100, 8'hCC, 1'b0, 1, "after_rst");

    force_zero = 1'b1;
    run_txn(8'hFF, 8'hFF, 3'b000, 8'h00, SELF, 0, "bad_alu");
    force_zero = 1'b0;
    chk("bad_alu mismatch", 32'(mismatch), 32'(SELF));
    run_txn(8'h0F, 8'hF0, 3'b010, 8'hFF, 1'b0, 0, "good_after_bad");
    chk("sticky mismatch", 32'(mismatch), 32'(SELF));
    do_reset();
    chk("mismatch cleared", 32'(mismatch), 32'd0);

    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] rx, ry;
      logic [2:0]   rop;
      rx  = W'($urandom);
      ry  = W'($urandom);
      rop = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(rx, ry, rop, ref_model(rx, ry, rop), (rop > 3'd5),
              int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_op_driver.md
BITWISE_OP_DRIVER -- requirements
Module: bitwise_op_driver

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter SETTLE_CYCLES, default 1, legal range 1..15, cycles alu_* are held before alu_result is sampled.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  driver can accept a request.
REQ-007 req_x / req_y  input  WIDTH  operands.
REQ-008 req_op  input  3  op code: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110/111 illegal.
REQ-009 alu_x / alu_y  output  WIDTH  operands driven to the bitwise operator unit.
REQ-010 alu_op_code  output  3  op code driven to the bitwise operator unit.
REQ-011 alu_result  input  WIDTH  combinational result returned by the bitwise operator unit.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_result / rsp_op  output  WIDTH / 3  captured result and its op code.
REQ-015 rsp_err  output  1  response is for an illegal op (or a self-check mismatch, REQ-030).
REQ-016 txn_count  output  16  completed response handshakes.
REQ-017 mismatch  output  1  sticky self-check failure flag.

Function
REQ-018 FSM states IDLE, DRIVE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE and req_valid, legal op: latch req_x/req_y/req_op into alu_x/alu_y/alu_op_code, load settle counter with SETTLE_CYCLES, go to DRIVE.
REQ-020 DRIVE: decrement counter each cycle; on the edge where counter reaches 0, register alu_result into rsp_result, alu_op_code into rsp_op, rsp_err=0, go to RESP.
REQ-021 Latency: with SETTLE_CYCLES=1, rsp_valid SHALL be high in the cycle immediately after the DRIVE cycle (2 edges after acceptance); each extra settle cycle adds one.
REQ-022 IDLE and req_valid, illegal op (110/111): alu_* unchanged, rsp_result=0, rsp_op=req_op, rsp_err=1, go directly to RESP (1 edge latency).
REQ-023 RESP: rsp_valid=1; rsp_result/rsp_op/rsp_err held stable until rsp_valid && rsp_ready; then go to IDLE and increment txn_count.
REQ-024 alu_* SHALL change only on request acceptance; they hold the last driven value in DRIVE, RESP and IDLE.
REQ-025 Requests arriving while req_ready=0 are not consumed; the requester holds them.
REQ-026 txn_count wraps 16'hFFFF -> 16'h0000 on the next handshake.
REQ-027 No back-to-back overlap: a new request SHALL be accepted no earlier than the cycle after the response handshake.

Reset
REQ-028 On rst high at a clock edge: state=IDLE, alu_x=alu_y=0, alu_op_code=000, rsp_valid=0, rsp_result=0, rsp_op=000, rsp_err=0, txn_count=0, mismatch=0, settle counter=0.
REQ-029 rst asserted in DRIVE or RESP SHALL discard the in-flight transaction without a response and without incrementing txn_count; rst has priority over all handshakes.

Configuration
REQ-030 With macro BITWISE_SELFCHECK_EN defined: an internal model computes the expected result from the latched alu_* values; at capture, if alu_result differs, rsp_err=1 for that response and mismatch sets and stays 1 until reset.
REQ-031 Without BITWISE_SELFCHECK_EN: no model is instantiated, mismatch SHALL be constant 0, rsp_err reflects illegal ops only; the port list is identical in both builds.

Verification
REQ-032 x=8'b00010101, y=8'b11000111, op=000 then 001 -> rsp_result 8'h05 then 8'hFA, rsp_err=0, txn_count 2.
REQ-033 x=8'b10010101, y=8'b01101111, op=010 then 011 -> 8'hFF then 8'h00; x=8'b01011001, y=8'b01101100, op=100 then 101 -> 8'h35 then 8'hCA; x=y=8'b01101100, op=101 -> 8'hFF.
REQ-034 rsp_ready held low 5 cycles during RESP -> rsp_valid/rsp_result stable, req_ready=0, new req_valid ignored; handshake then returns to IDLE, txn_count +1.
REQ-035 req_op=3'b110 -> rsp_valid one edge after acceptance, rsp_err=1, rsp_result=0, alu_* unchanged from previous transaction.
REQ-036 rst pulsed for one cycle during DRIVE -> no response, all outputs at REQ-028 values, txn_count=0; next request completes normally.
REQ-037 BITWISE_SELFCHECK_EN build, ALU model forced to return 8'h00 for AND 8'hFF & 8'hFF -> rsp_err=1, mismatch=1 held across later correct transactions until rst.
